sram_read_streamer: RTL and testbench

SRAM_READ_STREAMER -- requirements
Module: sram_read_streamer

---
 rtl/sram_read_streamer.sv | 160 ++++++++++++++++
 tb/tb_sram_read_streamer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_read_streamer.sv
// Streams a block of SRAM words through an arbiter client slot into a small output FIFO.
// Define SRAM_READ_STREAMER_LOOP_EN to replay the latched block forever instead of stopping after one pass.
module sram_read_streamer #(
  parameter int unsigned ADDRESS_BUS_WIDTH = 16,
  parameter int unsigned DATA_BUS_WIDTH    = 16,
  parameter int unsigned LENGTH_WIDTH      = 16,
  parameter int unsigned FIFO_DEPTH        = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDRESS_BUS_WIDTH-1:0] base_address,
  input  logic [LENGTH_WIDTH-1:0]      length,
  output logic                         busy,
  output logic                         done,
  output logic                         read_request,
  output logic [ADDRESS_BUS_WIDTH-1:0] read_address,
  input  logic                         read_finished_strobe,
  input  logic [DATA_BUS_WIDTH-1:0]    read_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_BUS_WIDTH-1:0]    out_data
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STALL, S_DRAIN} state_t;

  state_t                         r_state, w_state_next;
  logic [ADDRESS_BUS_WIDTH-1:0]   r_addr;
  logic [LENGTH_WIDTH-1:0]        r_remaining, w_rem_dec;
  logic                           r_req, r_done, w_done_next;
  logic [DATA_BUS_WIDTH-1:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]               r_wptr, r_rptr;
  logic [CNT_W-1:0]               r_count, w_count_next;
  logic                           w_accept, w_push, w_pop, w_space, w_last;
`ifdef SRAM_READ_STREAMER_LOOP_EN
  logic [ADDRESS_BUS_WIDTH-1:0]   r_base;
  logic [LENGTH_WIDTH-1:0]        r_len;
`endif

  assign w_accept  = (r_state == S_IDLE) && start;
  // Strobes outside FETCH belong to abandoned reads and are dropped here.
  assign w_push    = (r_state == S_FETCH) && read_finished_strobe;
  assign w_pop     = out_valid && out_ready;
  assign w_rem_dec = r_remaining - LENGTH_WIDTH'(1);
  assign w_last    = (w_rem_dec == '0);
  assign w_space   = (w_count_next < DEPTH_C);

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (length != '0) w_state_next = S_FETCH;
          else              w_done_next  = 1'b1;
        end
      end
      S_FETCH: begin
        if (w_push) begin
          if (!w_last) begin
            w_state_next = w_space ? S_FETCH : S_STALL;
          end else begin
`ifdef SRAM_READ_STREAMER_LOOP_EN
            w_done_next  = 1'b1;
            w_state_next = w_space ? S_FETCH : S_STALL;
`else
            w_state_next = S_DRAIN;
`endif
          end
        end
      end
      S_STALL: begin
        if (w_pop) w_state_next = S_FETCH;
      end
      S_DRAIN: begin
        if (w_count_next == '0) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_done      <= 1'b0;
      r_req       <= 1'b0;
      r_addr      <= '0;
      r_remaining <= '0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_next;
      // FETCH is only ever entered with FIFO space, so the flag tracks the next state.
      r_req   <= (w_state_next == S_FETCH);
      if (w_accept) begin
        r_addr      <= base_address;
        r_remaining <= length;
      end else if (w_push) begin
`ifdef SRAM_READ_STREAMER_LOOP_EN
        r_addr      <= w_last ? r_base : r_addr + ADDRESS_BUS_WIDTH'(1);
        r_remaining <= w_last ? r_len : w_rem_dec;
`else
        r_addr      <= r_addr + ADDRESS_BUS_WIDTH'(1);
        r_remaining <= w_rem_dec;
`endif
      end
    end
  end

`ifdef SRAM_READ_STREAMER_LOOP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_base <= '0;
      r_len  <= '0;
    end else if (w_accept) begin
      r_base <= base_address;
      r_len  <= length;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= read_data;
  end

  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;
  assign read_request = r_req & ~read_finished_strobe;
  assign read_address = r_addr;
  assign out_valid    = (r_count != '0);
  assign out_data     = r_mem[r_rptr];

endmodule

// File: tb/tb_sram_read_streamer.sv
// Scoreboard bench for sram_read_streamer: behavioural arbiter with configurable latency,
// expected words queued at start and compared as the output stream pops them.
module tb_sram_read_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_address = '0;
  logic [15:0] length = '0;
  logic        busy, done, read_request;
  logic [15:0] read_address;
  logic        read_finished_strobe = 1'b0;
  logic [15:0] read_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int strobe_cnt = 0;
  int req_cycles = 0;
  logic [15:0] exp_q[$];
  logic [15:0] addr_log[$];

  bit          arb_pend = 1'b0;
  bit          arb_check = 1'b1;
  bit          rand_ready = 1'b0;
  int          arb_cnt = 0;
  int          arb_lat = 3;
  logic [15:0] arb_addr = '0;

  sram_read_streamer #(
    .ADDRESS_BUS_WIDTH(16),
    .DATA_BUS_WIDTH(16),
    .LENGTH_WIDTH(16),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_address(base_address),
    .length(length),
    .busy(busy),
    .done(done),
    .read_request(read_request),
    .read_address(read_address),
    .read_finished_strobe(read_finished_strobe),
    .read_data(read_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] data_of(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  // One clock: pop check before the edge, then arbiter model and counters just after it.
  task automatic tick();
    logic [15:0] w;
    if (out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL out_data unexpected word got=%h expected=none", out_data);
      end else begin
        w = exp_q.pop_front();
        if (out_data !== w) begin
          failures++;
          $display("FAIL out_data got=%h expected=%h", out_data, w);
        end
      end
    end
    @(posedge clk);
    #1;
    if (done) done_cnt++;
    if (read_request) req_cycles++;
    if (read_finished_strobe) begin
      read_finished_strobe = 1'b0;
    end else if (arb_pend) begin
      arb_cnt--;
      if (arb_cnt == 0) begin
        if (arb_check) begin
          checks++;
          if (read_address !== arb_addr || read_request !== 1'b1) begin
            failures++;
            $display("FAIL req_stable addr=%h req=%0b expected addr=%h req=1", read_address, read_request, arb_addr);
          end
        end
        read_finished_strobe = 1'b1;
        read_data = data_of(arb_addr);
        arb_pend = 1'b0;
        strobe_cnt++;
      end
    end else if (read_request) begin
      arb_pend = 1'b1;
      arb_cnt = arb_lat;
      arb_addr = read_address;
      addr_log.push_back(read_address);
    end
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_state();
    done_cnt = 0;
    strobe_cnt = 0;
    req_cycles = 0;
    exp_q.delete();
    addr_log.delete();
  endtask

  task automatic expect_words(input logic [15:0] b, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(data_of(b + 16'(i)));
  endtask

  task automatic do_start(input logic [15:0] b, input logic [15:0] n);
    base_address = b;
    length = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    ok = (done_cnt != 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b expected=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b expected=0", done); end
    checks++; if (read_request !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b expected=0", read_request); end
    checks++; if (read_address !== 16'h0000) begin failures++; $display("FAIL reset_addr got=%h expected=0000", read_address); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b expected=0", out_valid); end
    rst = 1'b0;
    tick();
  endtask

`ifndef SRAM_READ_STREAMER_LOOP_EN
  task automatic test_basic();
    bit ok;
    logic [15:0] ea [3];
    ea = '{16'h0100, 16'h0101, 16'h0102};
    clear_state();
    arb_lat = 3;
    out_ready = 1'b1;
    expect_words(16'h0100, 3);
    do_start(16'h0100, 16'd3);
    tick();
    tick();
    do_start(16'h5555, 16'd5);
    wait_done(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_timeout done_cnt=%0d expected=1", done_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done got=%0b expected=0", busy); end
    repeat (4) tick();
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done_count got=%0d expected=1", done_cnt); end
    checks++; if (addr_log.size() != 3) begin failures++; $display("FAIL basic_req_count got=%0d expected=3", addr_log.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < addr_log.size()) begin
        checks++;
        if (addr_log[i] !== ea[i]) begin failures++; $display("FAIL basic_addr[%0d] got=%h expected=%h", i, addr_log[i], ea[i]); end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL basic_words_left got=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_state();
    arb_lat = 2;
    out_ready = 1'b0;
    expect_words(16'h0200, 8);
    do_start(16'h0200, 16'd8);
    repeat (40) tick();
    checks++; if (strobe_cnt != 4) begin failures++; $display("FAIL bp_strobes_stalled got=%0d expected=4", strobe_cnt); end
    checks++; if (read_request !== 1'b0) begin failures++; $display("FAIL bp_req_stalled got=%0b expected=0", read_request); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_stalled got=%0b expected=1", out_valid); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_busy_stalled got=%0b expected=1", busy); end
    out_ready = 1'b1;
    wait_done(300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_timeout done_cnt=%0d expected=1", done_cnt); end
    tick();
    checks++; if (strobe_cnt != 8) begin failures++; $display("FAIL bp_strobes got=%0d expected=8", strobe_cnt); end
    checks++; if (addr_log.size() != 8) begin failures++; $display("FAIL bp_req_count got=%0d expected=8", addr_log.size()); end
    for (int i = 0; i < 8; i++) begin
      if (i < addr_log.size()) begin
        checks++;
        if (addr_log[i] !== 16'h0200 + 16'(i)) begin failures++; $display("FAIL bp_addr[%0d] got=%h expected=%h", i, addr_log[i], 16'h0200 + 16'(i)); end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bp_words_left got=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [15:0] ea [4];
    ea = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    clear_state();
    arb_lat = 1;
    rand_ready = 1'b1;
    expect_words(16'hFFFE, 4);
    do_start(16'hFFFE, 16'd4);
    wait_done(300, ok);
    rand_ready = 1'b0;
    out_ready = 1'b1;
    checks++; if (!ok) begin failures++; $display("FAIL wrap_timeout done_cnt=%0d expected=1", done_cnt); end
    checks++; if (addr_log.size() != 4) begin failures++; $display("FAIL wrap_req_count got=%0d expected=4", addr_log.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < addr_log.size()) begin
        checks++;
        if (addr_log[i] !== ea[i]) begin failures++; $display("FAIL wrap_addr[%0d] got=%h expected=%h", i, addr_log[i], ea[i]); end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL wrap_words_left got=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_zero_len();
    clear_state();
    arb_lat = 3;
    do_start(16'h0040, 16'd0);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL zero_done_pulse got=%0b expected=1", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy got=%0b expected=0", busy); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL zero_done_clear got=%0b expected=0", done); end
    repeat (8) tick();
    checks++; if (req_cycles != 0) begin failures++; $display("FAIL zero_req_cycles got=%0d expected=0", req_cycles); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL zero_done_count got=%0d expected=1", done_cnt); end
  endtask

  task automatic test_reset_abandon();
    bit valid_seen;
    clear_state();
    arb_lat = 1;
    arb_check = 1'b0;
    out_ready = 1'b1;
    valid_seen = 1'b0;
    do_start(16'h0300, 16'd2);
    checks++; if (read_request !== 1'b1 || !arb_pend) begin failures++; $display("FAIL abandon_req_before_rst got=%0b expected=1", read_request); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (8) begin
      tick();
      if (out_valid) valid_seen = 1'b1;
    end
    checks++; if (strobe_cnt != 1) begin failures++; $display("FAIL abandon_late_strobe got=%0d expected=1", strobe_cnt); end
    checks++; if (valid_seen) begin failures++; $display("FAIL abandon_valid got=1 expected=0"); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abandon_busy got=%0b expected=0", busy); end
    checks++; if (addr_log.size() != 1) begin failures++; $display("FAIL abandon_req_count got=%0d expected=1", addr_log.size()); end
    arb_check = 1'b1;
    arb_lat = 3;
  endtask
`else
  task automatic test_loop();
    int n;
    clear_state();
    arb_lat = 2;
    out_ready = 1'b1;
    for (int p = 0; p < 5; p++) expect_words(16'h0010, 2);
    do_start(16'h0010, 16'd2);
    n = 0;
    while (done_cnt < 3 && n < 300) begin
      tick();
      n++;
    end
    checks++; if (done_cnt != 3) begin failures++; $display("FAIL loop_done_count got=%0d expected=3", done_cnt); end
    checks++; if (strobe_cnt != 6) begin failures++; $display("FAIL loop_strobes got=%0d expected=6", strobe_cnt); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL loop_busy got=%0b expected=1", busy); end
    checks++; if (addr_log.size() < 6) begin failures++; $display("FAIL loop_req_count got=%0d expected>=6", addr_log.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < addr_log.size()) begin
        checks++;
        if (addr_log[i] !== 16'h0010 + 16'(i % 2)) begin failures++; $display("FAIL loop_addr[%0d] got=%h expected=%h", i, addr_log[i], 16'h0010 + 16'(i % 2)); end
      end
    end
    arb_check = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    repeat (4) tick();
  endtask
`endif

  initial begin
    test_reset();
`ifdef SRAM_READ_STREAMER_LOOP_EN
    test_loop();
`else
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_len();
    test_reset_abandon();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
